// File: rtl/hazard_detect_unit_pkg.sv
// Shared definitions for the ID-stage hazard controller: register-index
// width, the hard-wired zero register and the controller state encoding.
package hazard_detect_unit_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_X0 = '0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   // A source operand depends on a destination only if it is actually read.
   function automatic logic src_matches(input logic             uses,
                                        input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rd);
      return uses && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection and branch squash control for the ID stage.
// Drives PC / IF/ID enables and the nop mux select; keeps a shadow copy of
// the load information of the instruction in EX and a saturating count of
// inserted load-use bubbles.
module hazard_detect_unit
   import hazard_detect_unit_pkg::*;
#(
   parameter int LOAD_USE_STALL = 1,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ID_rs1,
   input  logic [REG_W-1:0] ID_rs2,
   input  logic             ID_uses_rs1,
   input  logic             ID_uses_rs2,
   input  logic [REG_W-1:0] ID_rd,
   input  logic             ID_MemRead,
   input  logic             branch_taken,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             nopMux_Select,
   output logic [CNT_W-1:0] stall_count
);

   // Remaining-bubble counter preload after the first (hazard) bubble.
   localparam logic [2:0]       STALL_INIT = 3'(LOAD_USE_STALL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state_q;
   logic [2:0]       cnt_q;
   logic             ex_memread_q;
   logic [REG_W-1:0] ex_rd_q;
   logic [CNT_W-1:0] stall_count_q;
   logic [CNT_W-1:0] stall_count_d;
   logic             hazard;

   // A bubble in EX has ex_memread_q=0, so it can never trigger a hazard.
   assign hazard = ex_memread_q && (ex_rd_q != REG_X0) &&
                   (src_matches(ID_uses_rs1, ID_rs1, ex_rd_q) ||
                    src_matches(ID_uses_rs2, ID_rs2, ex_rd_q));

   // Pipeline control outputs: reset, then branch squash, then stall.
   always_comb begin
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      nopMux_Select = 1'b0;
      if (reset) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         IF_ID_Flush   = 1'b1;
         nopMux_Select = 1'b1;
      end else if (branch_taken) begin
         IF_ID_Flush   = 1'b1;
         nopMux_Select = 1'b1;
      end else if (state_q == ST_STALL || hazard) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         nopMux_Select = 1'b1;
      end
   end

   // Stall FSM: a hazard in RUN enters STALL only for multi-bubble builds.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
      end else if (branch_taken) begin
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
      end else if (state_q == ST_STALL) begin
         if (cnt_q <= 3'd1) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
         end else begin
            cnt_q <= cnt_q - 3'd1;
         end
      end else if (hazard && (LOAD_USE_STALL > 1)) begin
         state_q <= ST_STALL;
         cnt_q   <= STALL_INIT;
      end
   end

   // Shadow of the ID/EX load fields; a bubble enters EX as a non-load.
   always_ff @(posedge clk) begin
      if (reset || nopMux_Select) begin
         ex_memread_q <= 1'b0;
         ex_rd_q      <= REG_X0;
      end else begin
         ex_memread_q <= ID_MemRead;
         ex_rd_q      <= ID_rd;
      end
   end

   // Saturating count of load-use bubbles; branch squash cycles excluded.
   always_comb begin
      stall_count_d = stall_count_q;
      if (nopMux_Select && !branch_taken && (stall_count_q != CNT_MAX))
         stall_count_d = stall_count_q + 1'b1;
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: three builds (L=1/32-bit, L=3/32-bit,
// L=1/4-bit) share one stimulus stream and are each checked every cycle
// against an instruction-level reference model, plus pinned literal values.
module tb_hazard_detect_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, br;

   logic [2:0]  pw, iw, fl, nop;
   logic [31:0] sc0, sc1;
   logic [3:0]  sc2;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   hazard_detect_unit #(.LOAD_USE_STALL(1), .CNT_W(32)) dut0 (
      .clk(clk), .reset(reset), .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_uses_rs1(u1), .ID_uses_rs2(u2), .ID_rd(rd), .ID_MemRead(mr),
      .branch_taken(br), .PCWrite(pw[0]), .IF_ID_Write(iw[0]),
      .IF_ID_Flush(fl[0]), .nopMux_Select(nop[0]), .stall_count(sc0));

   hazard_detect_unit #(.LOAD_USE_STALL(3), .CNT_W(32)) dut1 (
      .clk(clk), .reset(reset), .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_uses_rs1(u1), .ID_uses_rs2(u2), .ID_rd(rd), .ID_MemRead(mr),
      .branch_taken(br), .PCWrite(pw[1]), .IF_ID_Write(iw[1]),
      .IF_ID_Flush(fl[1]), .nopMux_Select(nop[1]), .stall_count(sc1));

   hazard_detect_unit #(.LOAD_USE_STALL(1), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_uses_rs1(u1), .ID_uses_rs2(u2), .ID_rd(rd), .ID_MemRead(mr),
      .branch_taken(br), .PCWrite(pw[2]), .IF_ID_Write(iw[2]),
      .IF_ID_Flush(fl[2]), .nopMux_Select(nop[2]), .stall_count(sc2));

   // Reference model per build: what sits in EX, how many further bubbles
   // are owed, and the bubble tally.
   int     bubbles_per_hz [3] = '{1, 3, 1};
   longint cnt_max        [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   bit         m_ex_load [3];
   logic [4:0] m_ex_rd   [3];
   int         m_owed    [3];
   longint     m_cnt     [3];

   function automatic longint sc_of(int k);
      if (k == 0) return longint'(sc0);
      if (k == 1) return longint'(sc1);
      return longint'(sc2);
   endfunction

   task automatic check(string nm, longint act, longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: compare all builds against the model mid-cycle, then
   // advance the model to what the coming edge must produce.
   task automatic cyc();
      bit hz, e_pw, e_iw, e_fl, e_nop;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         hz = m_ex_load[k] && (m_ex_rd[k] != 5'd0) &&
              ((u1 && rs1 == m_ex_rd[k]) || (u2 && rs2 == m_ex_rd[k]));
         if (reset)                        {e_pw, e_iw, e_fl, e_nop} = 4'b0011;
         else if (br)                      {e_pw, e_iw, e_fl, e_nop} = 4'b1111;
         else if (m_owed[k] > 0 || hz)     {e_pw, e_iw, e_fl, e_nop} = 4'b0001;
         else                              {e_pw, e_iw, e_fl, e_nop} = 4'b1100;
         check($sformatf("dut%0d.PCWrite", k),       pw[k],  e_pw);
         check($sformatf("dut%0d.IF_ID_Write", k),   iw[k],  e_iw);
         check($sformatf("dut%0d.IF_ID_Flush", k),   fl[k],  e_fl);
         check($sformatf("dut%0d.nopMux_Select", k), nop[k], e_nop);
         check($sformatf("dut%0d.stall_count", k),   sc_of(k), m_cnt[k]);
         if (reset) begin
            m_ex_load[k] = 0; m_ex_rd[k] = 0; m_owed[k] = 0; m_cnt[k] = 0;
         end else begin
            if (e_nop && !br && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
            if (br)                 m_owed[k] = 0;
            else if (m_owed[k] > 0) m_owed[k]--;
            else if (hz)            m_owed[k] = bubbles_per_hz[k] - 1;
            m_ex_load[k] = e_nop ? 1'b0 : mr;
            m_ex_rd[k]   = e_nop ? 5'd0 : rd;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [4:0] a, input logic [4:0] b,
                        input logic ua, input logic ub,
                        input logic [4:0] d, input logic ld);
      rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; mr = ld;
   endtask

   task automatic bubble_instr();
      instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_ex_load[k] = 0; m_ex_rd[k] = 0; m_owed[k] = 0; m_cnt[k] = 0;
      end
      reset = 1'b1; br = 1'b0;
      bubble_instr();
      #1;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      check("reset.stall_count0", sc0, 0);
      check("reset.stall_count2", sc2, 0);
      cyc();

      // lw x5,0(x1) ; add x6,x5,x2
      instr(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1); cyc();
      instr(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0); #1;
      check("lu1.PCWrite", pw[0], 0);
      check("lu1.IF_ID_Write", iw[0], 0);
      check("lu1.nopMux", nop[0], 1);
      cyc(); #1;
      check("lu1.after.PCWrite", pw[0], 1);
      check("lu1.after.nopMux", nop[0], 0);
      check("lu3.stall2.PCWrite", pw[1], 0);
      cyc(); cyc();
      bubble_instr(); cyc(); cyc();
      check("lu1.stall_count", sc0, 1);
      check("lu3.stall_count", sc1, 3);

      // lw x7 ; reader of x7 through rs2 only
      instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1); cyc();
      instr(5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0); cyc(); cyc(); cyc();
      bubble_instr(); cyc();
      check("rs2.stall_count1", sc1, 6);
      check("rs2.stall_count0", sc0, 2);

      // same pair, but rs2 not actually read
      instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1); cyc();
      instr(5'd3, 5'd7, 1'b1, 1'b0, 5'd8, 1'b0); #1;
      check("no_rs2.nopMux", nop[1], 0);
      cyc(); bubble_instr(); cyc();

      // load to x0, then a reader of x0
      instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1); cyc();
      instr(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0); #1;
      check("x0.nopMux", nop[0], 0);
      cyc(); bubble_instr(); cyc();
      check("x0.stall_count0", sc0, 2);

      // taken branch in the second bubble of a 3-bubble stall
      instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1); cyc();
      instr(5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b0); cyc();
      br = 1'b1; #1;
      check("br.IF_ID_Flush", fl[1], 1);
      check("br.PCWrite", pw[1], 1);
      check("br.nopMux", nop[1], 1);
      cyc();
      br = 1'b0; bubble_instr(); #1;
      check("br.after.PCWrite", pw[1], 1);
      check("br.after.nopMux", nop[1], 0);
      cyc();
      check("br.stall_count1", sc1, 7);
      check("br.stall_count0", sc0, 3);

      // 20 load-use hazards: the 4-bit counter must stick at 15
      for (int i = 0; i < 20; i++) begin
         instr(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1); cyc();
         instr(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0); cyc(); cyc();
      end
      bubble_instr(); cyc(); cyc(); cyc();
      check("sat.stall_count2", sc2, 15);
      check("sat.stall_count0", sc0, 23);

      // reset in the middle of a 3-bubble stall
      instr(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1); cyc();
      instr(5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0); cyc();
      reset = 1'b1; #1;
      check("rst.PCWrite", pw[1], 0);
      check("rst.IF_ID_Write", iw[1], 0);
      check("rst.IF_ID_Flush", fl[1], 1);
      check("rst.nopMux", nop[1], 1);
      cyc();
      reset = 1'b0; bubble_instr(); #1;
      check("rst.after.PCWrite", pw[1], 1);
      check("rst.after.nopMux", nop[1], 0);
      check("rst.after.stall_count", sc1, 0);
      cyc();

      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom));
         br    = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 63) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
